game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Parametrised successor to the top-level game state/timer/HP logic.
- Owns the game FSM and the 1 Hz prescaler; adds a start-delay countdown, BCD time-left counter and saturating HP with invulnerability window.
- Also adds multi-level progression and a pause mode.
- Sits between Keyboard/Charactor and the LED, Seven_segment, Screen and Voice consumers.

Parameters:
TICK_CYCLES, 100_000_000, clk cycles per 1 s tick (bench overrides small)
START_DELAY_S, 3, WAIT-state countdown length in seconds (1..9)
TIME_MIN, 4, per-level start minutes (0..9)
TIME_SEC, 44, per-level start seconds (0..59)
HP_MAX, 7, HP on game start (1..2^HP_W-1)
HP_W, 3, HP width
LEVELS, 4, number of levels (1..2^LVL_W)
LVL_W, 2, level width
INVULN_S, 2, ticks of damage immunity after a hit (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-low (0 = reset)
enter  in  1  one-cycle pulse, Enter key
pause  in  1  one-cycle pulse, toggles pause
goal  in  1  level: character inside goal tile
dmg  in  1  one-cycle pulse, take 1 HP damage
heal  in  1  one-cycle pulse, gain 1 HP
state  out  3  INIT=0 WAIT=1 GAME=2 WIN=3 LOSE=4 PAUSE=5
level  out  LVL_W  current level, 0-based
countdown  out  4  WAIT seconds remaining, else 0
time_min  out  4  BCD minutes left
time_st  out  4  BCD seconds tens left
time_so  out  4  BCD seconds ones left
hp  out  HP_W  current HP
invuln  out  1  damage immunity active
tick  out  1  one-cycle pulse per second while WAIT/GAME

Behaviour:
- Reset (rst=0), async: state=INIT, level=0, countdown=0, time=TIME_MIN:TIME_SEC, hp=HP_MAX, invuln=0, tick=0, prescaler=0, internal invuln counter=0.
- Prescaler:
  - counts 0..TICK_CYCLES-1 only in WAIT/GAME; tick=1 the cycle it wraps; held in PAUSE.
  - cleared on every entry to WAIT, and on entry to GAME from WAIT. Not cleared on PAUSE->GAME resume.
- INIT/WIN/LOSE: enter -> WAIT, level=0, time reloaded, hp=HP_MAX, invuln=0, countdown=START_DELAY_S. WIN/LOSE hold time, hp and level until then.
- WAIT:
  - countdown decrements on each tick.
  - On the tick where countdown==1: ->GAME and countdown=0.
  - Other inputs ignored.
- GAME, per-cycle priority:
  1. goal -> if level==LEVELS-1: WIN (time frozen); else level+1, time reloaded, hp kept, ->WAIT with countdown=START_DELAY_S.
  2. hp==0 or time==0:00 -> LOSE.
  3. pause -> PAUSE.
- Timer (GAME only, on tick):
  - so-- when so>0.
  - else so=9; then st-- when st>0, else st=5 and min--.
  - Never decrements below 0:00; the 0:00 value is reached on the tick and LOSE follows the next cycle.
- PAUSE: pause -> GAME. Timer, prescaler, invuln counter and hp frozen; dmg/heal/goal/enter ignored.
- HP (GAME only):
  - dmg with invuln=0: hp-1, saturating at 0; invuln=1 and counter=INVULN_S if INVULN_S>0.
  - dmg with invuln=1: ignored.
  - heal: hp+1, saturating at HP_MAX.
  - dmg and heal in the same cycle: heal applied, and damage applied only if not invulnerable (net 0). Invulnerability still starts.
- Invuln counter: decrements on tick in GAME; invuln=0 when it reaches 0.
- All outputs registered; state changes visible the cycle after the causing input/tick.
- Mid-operation reset returns to the reset values immediately regardless of state.

Test Plan:
- TICK_CYCLES=10, START_DELAY_S=3: reset, enter -> state=1, countdown 3,2,1 at ticks, state=2 at 3rd tick (30 cycles after enter +1).
- TIME_MIN=0, TIME_SEC=10, LEVELS=1: reach GAME, no goal -> time 0:09..0:00 over 10 ticks, state=4 next cycle; time stays 0:00; enter -> WAIT, time=0:10, hp=7.
- LEVELS=2: goal in level 0 -> level=1, state=1, time reloaded, hp kept; goal in level 1 -> state=3, time frozen at value shown.
- INVULN_S=2: dmg, dmg next cycle -> hp 7->6 only, invuln=1 for 2 ticks. After the window, 6 further hits spaced 3 ticks apart -> hp=0, state=4 the cycle after hp reaches 0.
- hp=5, dmg+heal same cycle with invuln=0 -> hp stays 5, invuln=1. heal at hp=7 -> stays 7.
- In GAME at 4:30, pause -> state=5; 50 ticks' worth of cycles -> time still 4:30. pause -> state=2, next tick 4:29. Assert rst=0 mid-PAUSE -> state=0, hp=7, level=0 immediately.

Source files
------------

// File: rtl/game_flow_if.sv
// Bundle of the game-flow controls and status outputs. Keyboard/Charactor side
// drives the pulses and levels (master); game_flow_ctrl consumes them and
// drives the status seen by LED, Seven_segment, Screen and Voice (slave).
interface game_flow_if #(
  parameter int HP_W  = 3,
  parameter int LVL_W = 2
) ();
  logic             enter;
  logic             pause;
  logic             goal;
  logic             dmg;
  logic             heal;
  logic [2:0]       state;
  logic [LVL_W-1:0] level;
  logic [3:0]       countdown;
  logic [3:0]       time_min;
  logic [3:0]       time_st;
  logic [3:0]       time_so;
  logic [HP_W-1:0]  hp;
  logic             invuln;
  logic             tick;

  modport master (
    output enter, pause, goal, dmg, heal,
    input  state, level, countdown, time_min, time_st, time_so, hp, invuln, tick
  );

  modport slave (
    input  enter, pause, goal, dmg, heal,
    output state, level, countdown, time_min, time_st, time_so, hp, invuln, tick
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow controller: game FSM, 1 s prescaler, start-delay countdown,
// BCD time-left counter, multi-level progression, pause mode and saturating
// HP with a post-hit invulnerability window. All outputs are registered.
module game_flow_ctrl #(
  parameter int TICK_CYCLES   = 100_000_000,
  parameter int START_DELAY_S = 3,
  parameter int TIME_MIN      = 4,
  parameter int TIME_SEC      = 44,
  parameter int HP_MAX        = 7,
  parameter int HP_W          = 3,
  parameter int LEVELS        = 4,
  parameter int LVL_W         = 2,
  parameter int INVULN_S      = 2
) (
  input  logic       clk,
  input  logic       rst,
  game_flow_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GAME  = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  localparam int PS_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int INV_W = (INVULN_S > 0) ? $clog2(INVULN_S + 1) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_CYCLES - 1);
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_S);
  localparam logic [3:0]       CD_LOAD  = 4'(START_DELAY_S);
  localparam logic [3:0]       MIN_LOAD = 4'(TIME_MIN);
  localparam logic [3:0]       ST_LOAD  = 4'(TIME_SEC / 10);
  localparam logic [3:0]       SO_LOAD  = 4'(TIME_SEC % 10);
  localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(HP_MAX);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);
  localparam logic             INV_ON   = (INVULN_S > 0) ? 1'b1 : 1'b0;

  // One-second BCD decrement of M:ST:SO, clamped at 0:00.
  function automatic logic [11:0] bcd_time_dec(input logic [3:0] m,
                                               input logic [3:0] t,
                                               input logic [3:0] o);
    logic [11:0] r;
    if (o != 4'd0) begin
      r = {m, t, o - 4'd1};
    end else if (t != 4'd0) begin
      r = {m, t - 4'd1, 4'd9};
    end else if (m != 4'd0) begin
      r = {m - 4'd1, 4'd5, 4'd9};
    end else begin
      r = 12'd0;
    end
    return r;
  endfunction

  state_t           state_r;
  logic [LVL_W-1:0] level_r;
  logic [3:0]       countdown_r;
  logic [3:0]       min_r;
  logic [3:0]       st_r;
  logic [3:0]       so_r;
  logic [HP_W-1:0]  hp_r;
  logic             invuln_r;
  logic             tick_r;
  logic [PS_W-1:0]  presc_r;
  logic [INV_W-1:0] inv_cnt_r;

  logic             run_s;
  logic             tick_evt_s;
  logic             time_zero_s;
  logic             hit_s;
  logic [11:0]      time_dec_s;
  logic [HP_W-1:0]  hp_next_s;

  // Tick detection, timer decrement value and combined dmg/heal HP update.
  always_comb begin
    run_s       = (state_r == ST_WAIT) || (state_r == ST_GAME);
    tick_evt_s  = run_s && (presc_r == PS_LAST);
    time_zero_s = (min_r == 4'd0) && (st_r == 4'd0) && (so_r == 4'd0);
    time_dec_s  = bcd_time_dec(min_r, st_r, so_r);
    hit_s       = bus.dmg && !invuln_r;
    // A simultaneous heal and landed hit cancel out.
    if (bus.heal && hit_s) begin
      hp_next_s = hp_r;
    end else if (bus.heal) begin
      hp_next_s = (hp_r == HP_FULL) ? hp_r : hp_r + HP_W'(1);
    end else if (hit_s) begin
      hp_next_s = (hp_r == {HP_W{1'b0}}) ? hp_r : hp_r - HP_W'(1);
    end else begin
      hp_next_s = hp_r;
    end
  end

  // Game FSM with prescaler, countdown, timer, level, HP and invulnerability state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_INIT;
      level_r     <= {LVL_W{1'b0}};
      countdown_r <= 4'd0;
      min_r       <= MIN_LOAD;
      st_r        <= ST_LOAD;
      so_r        <= SO_LOAD;
      hp_r        <= HP_FULL;
      invuln_r    <= 1'b0;
      tick_r      <= 1'b0;
      presc_r     <= {PS_W{1'b0}};
      inv_cnt_r   <= {INV_W{1'b0}};
    end else begin
      tick_r <= tick_evt_s;
      // Prescaler runs only in WAIT/GAME; PAUSE and idle states hold it.
      if (tick_evt_s) begin
        presc_r <= {PS_W{1'b0}};
      end else if (run_s) begin
        presc_r <= presc_r + PS_W'(1);
      end else begin
        presc_r <= presc_r;
      end

      case (state_r)
        ST_INIT, ST_WIN, ST_LOSE: begin
          // Fresh game: level 0, full HP, no immunity, start-delay countdown.
          if (bus.enter) begin
            state_r     <= ST_WAIT;
            level_r     <= {LVL_W{1'b0}};
            countdown_r <= CD_LOAD;
            min_r       <= MIN_LOAD;
            st_r        <= ST_LOAD;
            so_r        <= SO_LOAD;
            hp_r        <= HP_FULL;
            invuln_r    <= 1'b0;
            inv_cnt_r   <= {INV_W{1'b0}};
            presc_r     <= {PS_W{1'b0}};
          end
        end

        ST_WAIT: begin
          if (tick_evt_s) begin
            if (countdown_r == 4'd1) begin
              state_r     <= ST_GAME;
              countdown_r <= 4'd0;
              presc_r     <= {PS_W{1'b0}};
            end else begin
              countdown_r <= countdown_r - 4'd1;
            end
          end
        end

        ST_GAME: begin
          if (bus.goal) begin
            if (level_r == LVL_LAST) begin
              // Time, HP and level stay on display until the next enter.
              state_r <= ST_WIN;
            end else begin
              state_r     <= ST_WAIT;
              level_r     <= level_r + LVL_W'(1);
              countdown_r <= CD_LOAD;
              min_r       <= MIN_LOAD;
              st_r        <= ST_LOAD;
              so_r        <= SO_LOAD;
              presc_r     <= {PS_W{1'b0}};
            end
          end else begin
            if ((hp_r == {HP_W{1'b0}}) || time_zero_s) begin
              state_r <= ST_LOSE;
            end else if (bus.pause) begin
              state_r <= ST_PAUSE;
            end else begin
              state_r <= ST_GAME;
            end

            if (tick_evt_s) begin
              {min_r, st_r, so_r} <= time_dec_s;
            end

            hp_r <= hp_next_s;

            // A landed hit (re)starts the window; otherwise it drains on ticks.
            if (hit_s && INV_ON) begin
              invuln_r  <= 1'b1;
              inv_cnt_r <= INV_LOAD;
            end else if (invuln_r && tick_evt_s) begin
              if (inv_cnt_r <= INV_W'(1)) begin
                inv_cnt_r <= {INV_W{1'b0}};
                invuln_r  <= 1'b0;
              end else begin
                inv_cnt_r <= inv_cnt_r - INV_W'(1);
              end
            end
          end
        end

        ST_PAUSE: begin
          if (bus.pause) begin
            state_r <= ST_GAME;
          end
        end

        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.state     = state_r;
  assign bus.level     = level_r;
  assign bus.countdown = countdown_r;
  assign bus.time_min  = min_r;
  assign bus.time_st   = st_r;
  assign bus.time_so   = so_r;
  assign bus.hp        = hp_r;
  assign bus.invuln    = invuln_r;
  assign bus.tick      = tick_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl. Two instances share clock and reset:
// A (0:10 per level, 2 levels) covers countdown, timeout, levels and win;
// B (4:30 per level, 4 levels) covers pause, HP, invulnerability and reset.
module tb_game_flow_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  game_flow_if #(.HP_W(3), .LVL_W(2)) ia ();
  game_flow_if #(.HP_W(3), .LVL_W(2)) ib ();

  game_flow_ctrl #(
    .TICK_CYCLES(10), .START_DELAY_S(3), .TIME_MIN(0), .TIME_SEC(10),
    .HP_MAX(7), .HP_W(3), .LEVELS(2), .LVL_W(2), .INVULN_S(2)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );

  game_flow_ctrl #(
    .TICK_CYCLES(10), .START_DELAY_S(3), .TIME_MIN(4), .TIME_SEC(30),
    .HP_MAX(7), .HP_W(3), .LEVELS(4), .LVL_W(2), .INVULN_S(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ia.enter = 1'b0; ia.pause = 1'b0; ia.goal = 1'b0; ia.dmg = 1'b0; ia.heal = 1'b0;
    ib.enter = 1'b0; ib.pause = 1'b0; ib.goal = 1'b0; ib.dmg = 1'b0; ib.heal = 1'b0;
    step(2);

    // Reset values
    chk("rst_state",  32'(ia.state), 32'd0);
    chk("rst_level",  32'(ia.level), 32'd0);
    chk("rst_cd",     32'(ia.countdown), 32'd0);
    chk("rst_time_a", 32'({ia.time_min, ia.time_st, ia.time_so}), 32'h010);
    chk("rst_time_b", 32'({ib.time_min, ib.time_st, ib.time_so}), 32'h430);
    chk("rst_hp",     32'(ia.hp), 32'd7);
    chk("rst_invuln", 32'(ia.invuln), 32'd0);
    chk("rst_tick",   32'(ia.tick), 32'd0);
    rst = 1'b1;
    step(2);
    chk("init_idle", 32'(ia.state), 32'd0);

    // A: start delay 3,2,1 then GAME on the third tick
    ia.enter = 1'b1; step(1); ia.enter = 1'b0;
    chk("a_wait",      32'(ia.state), 32'd1);
    chk("a_cd3",       32'(ia.countdown), 32'd3);
    step(9);
    chk("a_cd3_hold",  32'(ia.countdown), 32'd3);
    chk("a_tick_low",  32'(ia.tick), 32'd0);
    step(1);
    chk("a_cd2",       32'(ia.countdown), 32'd2);
    chk("a_tick_high", 32'(ia.tick), 32'd1);
    step(10);
    chk("a_cd1",       32'(ia.countdown), 32'd1);
    step(10);
    chk("a_game",      32'(ia.state), 32'd2);
    chk("a_cd0",       32'(ia.countdown), 32'd0);
    chk("a_time_10",   32'({ia.time_min, ia.time_st, ia.time_so}), 32'h010);

    // A: timeout 0:10 -> 0:00, LOSE the cycle after
    step(10);
    chk("a_time_09",   32'({ia.time_min, ia.time_st, ia.time_so}), 32'h009);
    step(90);
    chk("a_time_00",   32'({ia.time_min, ia.time_st, ia.time_so}), 32'h000);
    chk("a_game_at0",  32'(ia.state), 32'd2);
    step(1);
    chk("a_lose",      32'(ia.state), 32'd4);
    step(20);
    chk("a_lose_hold", 32'(ia.state), 32'd4);
    chk("a_time_hold", 32'({ia.time_min, ia.time_st, ia.time_so}), 32'h000);
    chk("a_tick_idle", 32'(ia.tick), 32'd0);
    ia.enter = 1'b1; step(1); ia.enter = 1'b0;
    chk("a_rewait",    32'(ia.state), 32'd1);
    chk("a_reload",    32'({ia.time_min, ia.time_st, ia.time_so}), 32'h010);
    chk("a_rehp",      32'(ia.hp), 32'd7);
    chk("a_recd",      32'(ia.countdown), 32'd3);

    // A: level progression keeps HP, last-level goal wins with time frozen
    step(30);
    chk("a_game2",     32'(ia.state), 32'd2);
    ia.dmg = 1'b1; step(1); ia.dmg = 1'b0;
    chk("a_hp6",       32'(ia.hp), 32'd6);
    ia.goal = 1'b1; step(1); ia.goal = 1'b0;
    chk("a_lvl1",      32'(ia.level), 32'd1);
    chk("a_goal_wait", 32'(ia.state), 32'd1);
    chk("a_goal_time", 32'({ia.time_min, ia.time_st, ia.time_so}), 32'h010);
    chk("a_goal_hp",   32'(ia.hp), 32'd6);
    chk("a_goal_cd",   32'(ia.countdown), 32'd3);
    step(30);
    chk("a_game3",     32'(ia.state), 32'd2);
    step(10);
    chk("a_l1_time",   32'({ia.time_min, ia.time_st, ia.time_so}), 32'h009);
    ia.goal = 1'b1; step(1); ia.goal = 1'b0;
    chk("a_win",       32'(ia.state), 32'd3);
    step(15);
    chk("a_win_hold",  32'(ia.state), 32'd3);
    chk("a_win_time",  32'({ia.time_min, ia.time_st, ia.time_so}), 32'h009);
    chk("a_win_lvl",   32'(ia.level), 32'd1);
    ia.enter = 1'b1; step(1); ia.enter = 1'b0;
    chk("a_win_enter", 32'(ia.state), 32'd1);
    chk("a_win_lvl0",  32'(ia.level), 32'd0);

    // B: reach GAME at 4:30, pause freezes everything, resume keeps prescaler
    ib.enter = 1'b1; step(1); ib.enter = 1'b0;
    step(30);
    chk("b_game",       32'(ib.state), 32'd2);
    chk("b_time_430",   32'({ib.time_min, ib.time_st, ib.time_so}), 32'h430);
    ib.pause = 1'b1; step(1); ib.pause = 1'b0;
    chk("b_pause",      32'(ib.state), 32'd5);
    step(500);
    chk("b_pause_hold", 32'(ib.state), 32'd5);
    chk("b_pause_time", 32'({ib.time_min, ib.time_st, ib.time_so}), 32'h430);
    chk("b_pause_tick", 32'(ib.tick), 32'd0);
    ib.pause = 1'b1; step(1); ib.pause = 1'b0;
    chk("b_resume",     32'(ib.state), 32'd2);
    step(8);
    chk("b_pre_tick",   32'({ib.time_min, ib.time_st, ib.time_so}), 32'h430);
    step(1);
    chk("b_time_429",   32'({ib.time_min, ib.time_st, ib.time_so}), 32'h429);
    chk("b_tick",       32'(ib.tick), 32'd1);

    // B: hit, immune back-to-back hit, 2-tick window
    ib.dmg = 1'b1; step(1); ib.dmg = 1'b0;
    chk("b_hit_hp6",    32'(ib.hp), 32'd6);
    chk("b_inv_on",     32'(ib.invuln), 32'd1);
    ib.dmg = 1'b1; step(1); ib.dmg = 1'b0;
    chk("b_immune_hp",  32'(ib.hp), 32'd6);
    step(8);
    chk("b_inv_tick1",  32'(ib.invuln), 32'd1);
    step(10);
    chk("b_inv_off",    32'(ib.invuln), 32'd0);
    chk("b_hp6_after",  32'(ib.hp), 32'd6);

    ib.dmg = 1'b1; step(1); ib.dmg = 1'b0;
    chk("b_hp5",        32'(ib.hp), 32'd5);
    step(29);
    ib.dmg = 1'b1; ib.heal = 1'b1; step(1); ib.dmg = 1'b0; ib.heal = 1'b0;
    chk("b_dmgheal_hp", 32'(ib.hp), 32'd5);
    chk("b_dmgheal_inv", 32'(ib.invuln), 32'd1);
    step(29);
    for (int k = 0; k < 5; k++) begin
      ib.dmg = 1'b1; step(1); ib.dmg = 1'b0;
      chk($sformatf("b_hit%0d", k), 32'(ib.hp), 32'(4 - k));
      if (k < 4) step(29);
    end
    chk("b_hp0_game",   32'(ib.state), 32'd2);
    step(1);
    chk("b_hp0_lose",   32'(ib.state), 32'd4);

    // B: heal saturation, then reset in the middle of PAUSE
    ib.enter = 1'b1; step(1); ib.enter = 1'b0;
    chk("b_restart_hp", 32'(ib.hp), 32'd7);
    step(30);
    ib.heal = 1'b1; step(1); ib.heal = 1'b0;
    chk("b_heal_sat",   32'(ib.hp), 32'd7);
    ib.dmg = 1'b1; step(1); ib.dmg = 1'b0;
    ib.goal = 1'b1; step(1); ib.goal = 1'b0;
    chk("b_goal_lvl",   32'(ib.level), 32'd1);
    step(30);
    ib.pause = 1'b1; step(1); ib.pause = 1'b0;
    chk("b_pause2",     32'(ib.state), 32'd5);
    chk("b_pause2_hp",  32'(ib.hp), 32'd6);
    chk("b_pause2_inv", 32'(ib.invuln), 32'd1);
    rst = 1'b0;
    #1;
    chk("b_arst_state", 32'(ib.state), 32'd0);
    chk("b_arst_hp",    32'(ib.hp), 32'd7);
    chk("b_arst_lvl",   32'(ib.level), 32'd0);
    chk("b_arst_inv",   32'(ib.invuln), 32'd0);
    chk("b_arst_time",  32'({ib.time_min, ib.time_st, ib.time_so}), 32'h430);
    step(1);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
